disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl_pkg.sv | 21 ++
 rtl/disp_scan_ctrl_clk_prescaler.sv | 22 ++
 rtl/disp_scan_ctrl.sv | 93 +++++++++
 tb/tb_disp_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared display constants and the buffered frame record used by the scan controller.
package disp_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 3;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = 8'hFF;

  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] hexs;
    logic [NUM_DIGITS-1:0]         points;
    logic [NUM_DIGITS-1:0]         les;
    logic [NUM_DIGITS-1:0]         blinks;
  } disp_buf_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [NUM_DIGITS-1:0] an_onecold(input logic [IDX_W-1:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_clk_prescaler.sv
// Free-running binary prescaler; tick is high for the one cycle the count is all-ones.
module clk_prescaler #(
  parameter int WIDTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    tick  = &cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with double-buffered frame data,
// a one-cycle blanking gap between digits and a per-digit blink gate.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hexs,
  input  logic [7:0]  points,
  input  logic [7:0]  les,
  input  logic [7:0]  blinks,
  input  logic        load,
  output logic [3:0]  Hex,
  output logic        LE,
  output logic        point,
  output logic        flash,
  output logic [7:0]  AN
);

  logic scan_tick, blink_tick, wrap;

  logic [IDX_W-1:0]      idx_q, idx_d;
  disp_buf_t             pend_q, pend_d;
  disp_buf_t             act_q, act_d;
  logic                  phase_q, phase_d;
  logic [DIGIT_W-1:0]    hex_q, hex_d;
  logic                  le_q, le_d;
  logic                  point_q, point_d;
  logic                  flash_q, flash_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  clk_prescaler #(.WIDTH(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (scan_tick)
  );

  // Low BLINK_DIV-1 bits of the blink counter; phase_q is its MSB.
  clk_prescaler #(.WIDTH(BLINK_DIV-1)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (blink_tick)
  );

  always_comb begin
    wrap    = scan_tick && (idx_q == 3'd7);
    idx_d   = scan_tick ? idx_q + 3'd1 : idx_q;
    act_d   = wrap ? pend_q : act_q;
    pend_d  = load ? disp_buf_t'{hexs, points, les, blinks} : pend_q;
    phase_d = phase_q ^ blink_tick;

    // Outputs are computed from next-state so they move on the same edge as the index.
    hex_d   = act_d.hexs[{idx_d, 2'b00} +: DIGIT_W];
    le_d    = act_d.les[idx_d];
    point_d = act_d.points[idx_d];
    flash_d = ~act_d.blinks[idx_d] | ~phase_d;
    an_d    = scan_tick ? AN_IDLE : an_onecold(idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= '0;
      le_q    <= 1'b0;
      point_q <= 1'b0;
      flash_q <= 1'b1;
      an_q    <= 8'hFE;
    end else begin
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
      le_q    <= le_d;
      point_q <= point_d;
      flash_q <= flash_d;
      an_q    <= an_d;
    end
  end

  assign Hex   = hex_q;
  assign LE    = le_q;
  assign point = point_q;
  assign flash = flash_q;
  assign AN    = an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench: a cycle-count reference model pushes expected outputs, a monitor pops and compares.
module tb_disp_scan_ctrl;

  localparam int S = 2;
  localparam int B = 4;
  localparam int P = 1 << S;
  localparam int F = 8 * P;
  localparam int H = 1 << (B - 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hexs;
  logic [7:0]  points, les, blinks;
  logic        load;
  logic [3:0]  Hex;
  logic        LE, point, flash;
  logic [7:0]  AN;

  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hexs   (hexs),
    .points (points),
    .les    (les),
    .blinks (blinks),
    .load   (load),
    .Hex    (Hex),
    .LE     (LE),
    .point  (point),
    .flash  (flash),
    .AN     (AN)
  );

  typedef struct {
    logic [3:0] hex;
    logic       le;
    logic       point;
    logic       flash;
    logic [7:0] an;
    int         k;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: k = clock edges since reset release.
  int          k = 0;
  logic [31:0] p_hex, a_hex;
  logic [7:0]  p_pt, a_pt, p_le, a_le, p_bl, a_bl;

  initial begin
    exp_t e;
    int   idx;
    p_hex = 0; a_hex = 0; p_pt = 0; a_pt = 0;
    p_le = 0;  a_le = 0;  p_bl = 0; a_bl = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        p_hex = 0; a_hex = 0; p_pt = 0; a_pt = 0;
        p_le = 0;  a_le = 0;  p_bl = 0; a_bl = 0;
      end else begin
        k++;
        if (k % F == 0) begin
          a_hex = p_hex; a_pt = p_pt; a_le = p_le; a_bl = p_bl;
        end
        if (load) begin
          p_hex = hexs; p_pt = points; p_le = les; p_bl = blinks;
        end
      end
      idx     = (k / P) % 8;
      e.an    = (k != 0 && k % P == 0) ? 8'hFF : ~(8'h01 << idx);
      e.hex   = a_hex[idx*4 +: 4];
      e.le    = a_le[idx];
      e.point = a_pt[idx];
      e.flash = !(a_bl[idx] && ((k / H) % 2 == 1));
      e.k     = k;
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Hex !== e.hex || LE !== e.le || point !== e.point || flash !== e.flash || AN !== e.an) begin
          errors++;
          $display("FAIL outputs k=%0d: got Hex=%h LE=%b point=%b flash=%b AN=%h, want Hex=%h LE=%b point=%b flash=%b AN=%h",
                   e.k, Hex, LE, point, flash, AN, e.hex, e.le, e.point, e.flash, e.an);
        end
        checks++;
        assert (!$isunknown(AN) && $countones(~AN) <= 1)
        else begin
          errors++;
          $display("FAIL an_onecold k=%0d: got AN=%h, want at most one bit low", e.k, AN);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic noise();
    hexs   = $urandom;
    points = 8'($urandom);
    les    = 8'($urandom);
    blinks = 8'($urandom);
  endtask

  task automatic do_load(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l,
                         input logic [7:0] b);
    hexs = h; points = p; les = l; blinks = b; load = 1'b1;
    step();
    load = 1'b0;
    noise();
  endtask

  // Advance until the next rising edge is edge number k+1 with the given digit and prescaler offset.
  task automatic wait_for(input int idx_t, input int off_t, input string name);
    int n = 0;
    while (!((((k + 1) / P) % 8 == idx_t) && ((k + 1) % P == off_t))) begin
      step();
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL %s: got no matching cycle within 500, want digit %0d offset %0d", name, idx_t, off_t);
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0;
    hexs = 0; points = 0; les = 0; blinks = 0;
    step();
    // load during reset must be ignored
    hexs = 32'hDEADBEEF; les = 8'hFF; load = 1'b1;
    repeat (2) step();
    load = 1'b0;
    rst_n = 1'b1;

    do_load(32'h76543210, 8'($urandom), 8'hFF, 8'h00);
    repeat (2 * F) step();

    wait_for(3, 1, "mid_frame_load");
    do_load(32'hAAAAAAAA, 8'h00, 8'hFF, 8'h00);
    repeat (F + 2 * P) step();

    wait_for(0, 0, "wrap_load");
    do_load($urandom, 8'($urandom), 8'hFF, 8'h00);
    repeat (2 * F) step();

    do_load($urandom, 8'($urandom), 8'hFF, 8'h01);
    repeat (3 * F) step();

    do_load($urandom, 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (F) step();
    wait_for(4, 1, "pre_reset_load");
    do_load(32'h12345678, 8'hFF, 8'hFF, 8'h00);
    wait_for(5, 1, "mid_frame_reset");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (F + P) step();

    for (int i = 0; i < 800; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      noise();
      if ($urandom_range(0, 3) == 0) blinks = 8'h00;
      step();
    end
    load = 1'b0; rst_n = 1'b1;
    repeat (2 * F) step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
